// File: rtl/sixteen_bit_down_counter.sv
// Loadable 16-bit interval timer: counts a start value down to zero on prescaled ticks, pulses done at terminal count.
// Latency: load visible on count the edge after acceptance; value N reaches 0 after N*PRESCALE enabled cycles.
// Backpressure: load_ready is high only in IDLE; loads offered during RUN are ignored. Optional auto-reload under SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN.
module sixteen_bit_down_counter #(
   parameter int PRESCALE = 1   // enabled RUN cycles per decrement tick, 1..256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   input  logic        enable,
   input  logic        abort,
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
   input  logic        auto_reload,
`endif
   output logic [15:0] count,
   output logic        busy,
   output logic        done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // Prescaler is 8 bits wide, enough for PRESCALE up to 256.
   localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  presc_q, presc_d;
   logic        done_q,  done_d;
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
   logic [15:0] reload_q, reload_d;
`endif

   logic        reload_active;
   logic        tick;
   logic [3:0]  brw;        // borrow into each nibble slice
   logic [15:0] count_dec;

`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
   assign reload_active = auto_reload;
`else
   assign reload_active = 1'b0;
`endif

   assign tick = (state_q == RUN) && enable && (presc_q == PRESC_LAST);

   // Decrement as four ripple-borrow nibble slices; the top nibble's borrow-out is never needed.
   always_comb begin
      brw[0] = 1'b1;
      for (int i = 1; i < 4; i++) begin
         brw[i] = brw[i-1] & (count_q[4*(i-1) +: 4] == 4'h0);
      end
      for (int i = 0; i < 4; i++) begin
         count_dec[4*i +: 4] = count_q[4*i +: 4] - {3'b000, brw[i]};
      end
   end

   // Next-state logic: load in IDLE, prescaled countdown/abort/terminal handling in RUN.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      presc_d  = presc_q;
      done_d   = 1'b0;
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
      reload_d = reload_q;
`endif
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               count_d  = load_data;
               presc_d  = 8'h00;
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
               reload_d = load_data;
`endif
               // A zero start value is a zero-length interval: done right away, never enter RUN.
               if (load_data != 16'h0000) begin
                  state_d = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               // Abort outranks a coincident terminal tick: count frozen, no done.
               state_d = IDLE;
               presc_d = 8'h00;
            end else if (tick) begin
               presc_d = 8'h00;
               if (count_q == 16'h0001) begin
                  done_d = 1'b1;
                  if (reload_active) begin
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
                     count_d = reload_q;
`endif
                  end else begin
                     count_d = 16'h0000;
                     state_d = IDLE;
                  end
               end else begin
                  count_d = count_dec;
               end
            end else if (enable) begin
               presc_d = presc_q + 8'h01;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         count_q  <= 16'h0000;
         presc_q  <= 8'h00;
         done_q   <= 1'b0;
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
         reload_q <= 16'h0000;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         presc_q  <= presc_d;
         done_q   <= done_d;
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign count      = count_q;
   assign busy       = (state_q == RUN);
   assign load_ready = (state_q == IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_sixteen_bit_down_counter.sv
// Bench for sixteen_bit_down_counter: two instances (PRESCALE 1 and 4) checked against an interval-level model.
// Model tracks start value and enabled-cycle count; expected count = N - elapsed/P.
// Directed scenarios followed by randomized stimulus.
module tb_sixteen_bit_down_counter;

   logic        clk;
   logic        reset;
   logic        lv    [2];
   logic [15:0] ld    [2];
   logic        en    [2];
   logic        ab    [2];
   logic        ar    [2];
   logic [15:0] cnt_o [2];
   logic        busy_o[2];
   logic        done_o[2];
   logic        rdy_o [2];

   int tests = 0;
   int fails = 0;
   int P [2] = '{1, 4};

   // Model state
   bit          m_run [2];
   int          m_N   [2];
   int          m_e   [2];
   logic [15:0] m_cnt [2];
   bit          m_done[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sixteen_bit_down_counter #(.PRESCALE(1)) u_dut1 (
      .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(rdy_o[0]),
      .enable(en[0]), .abort(ab[0]),
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
      .auto_reload(ar[0]),
`endif
      .count(cnt_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   sixteen_bit_down_counter #(.PRESCALE(4)) u_dut4 (
      .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(rdy_o[1]),
      .enable(en[1]), .abort(ab[1]),
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
      .auto_reload(ar[1]),
`endif
      .count(cnt_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   // Interval-level reference model
   bit          r_n, d_n, arl;
   int          n_n, e_n;
   logic [15:0] c_n;
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         r_n = m_run[i]; n_n = m_N[i]; e_n = m_e[i]; c_n = m_cnt[i]; d_n = 1'b0;
         arl = 1'b0;
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
         arl = ar[i];
`endif
         if (!reset) begin
            r_n = 1'b0; n_n = 0; e_n = 0; c_n = 16'h0000;
         end else if (!r_n) begin
            if (lv[i]) begin
               n_n = int'(ld[i]); e_n = 0; c_n = ld[i];
               if (n_n != 0) r_n = 1'b1; else d_n = 1'b1;
            end
         end else if (ab[i]) begin
            r_n = 1'b0;
         end else if (en[i]) begin
            e_n = e_n + 1;
            if (e_n == n_n * P[i]) begin
               d_n = 1'b1;
               if (arl) begin e_n = 0; c_n = 16'(n_n); end
               else begin r_n = 1'b0; c_n = 16'h0000; end
            end else begin
               c_n = 16'(n_n - e_n / P[i]);
            end
         end
         m_run[i] <= r_n; m_N[i] <= n_n; m_e[i] <= e_n; m_cnt[i] <= c_n; m_done[i] <= d_n;
      end
   end

   function automatic logic [18:0] obs(int i);
      return {cnt_o[i], busy_o[i], done_o[i], rdy_o[i]};
   endfunction

   function automatic logic [18:0] expv(int i);
      return {m_cnt[i], m_run[i], m_done[i], ~m_run[i]};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         lv[i] = 1'b0; ld[i] = 16'h0000; en[i] = 1'b0; ab[i] = 1'b0; ar[i] = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      step(); step();
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (obs(i) !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset inst%0d: got %h required %h", i, obs(i), {16'h0000, 3'b001});
         end
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_countdown_p1();
      logic [15:0] exp_seq [4] = '{16'd3, 16'd2, 16'd1, 16'd0};
      en[0] = 1'b1; lv[0] = 1'b1; ld[0] = 16'h0003;
      step();
      lv[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         tests++;
         if (cnt_o[0] !== exp_seq[k] || obs(0) !== expv(0)) begin
            fails++;
            $display("FAIL countdown k=%0d: got %h required count %h model %h", k, obs(0), exp_seq[k], expv(0));
         end
      end
      tests++;
      if (done_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || rdy_o[0] !== 1'b1) begin
         fails++;
         $display("FAIL done_pulse: done=%b busy=%b ready=%b required 1 0 1", done_o[0], busy_o[0], rdy_o[0]);
      end
      // back-to-back load in the done cycle
      lv[0] = 1'b1; ld[0] = 16'h0005;
      step();
      lv[0] = 1'b0;
      tests++;
      if (cnt_o[0] !== 16'h0005 || busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
         fails++;
         $display("FAIL back_to_back: count=%h busy=%b done=%b required 0005 1 0", cnt_o[0], busy_o[0], done_o[0]);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         tests++;
         if (obs(0) !== expv(0)) begin
            fails++;
            $display("FAIL b2b_run k=%0d: got %h required %h", k, obs(0), expv(0));
         end
      end
      en[0] = 1'b0;
   endtask

   task automatic test_borrow_p4();
      int done_at;
      en[1] = 1'b1; lv[1] = 1'b1; ld[1] = 16'h1000;
      step();
      lv[1] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         tests++;
         if (cnt_o[1] !== ((k < 4) ? 16'h1000 : 16'h0FFF)) begin
            fails++;
            $display("FAIL borrow k=%0d: got %h required %h", k, cnt_o[1], (k < 4) ? 16'h1000 : 16'h0FFF);
         end
      end
      ab[1] = 1'b1;
      step();
      ab[1] = 1'b0;
      tests++;
      if (obs(1) !== {16'h0FFF, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL abort_hold: got %h required %h", obs(1), {16'h0FFF, 3'b001});
      end
      // N=3, P=4 is 12 enabled cycles; three disabled cycles stretch it to 15
      lv[1] = 1'b1; ld[1] = 16'h0003;
      step();
      lv[1] = 1'b0;
      done_at = -1;
      for (int c = 1; c <= 40 && done_at < 0; c++) begin
         en[1] = !(c >= 2 && c <= 4);
         step();
         tests++;
         if (obs(1) !== expv(1)) begin
            fails++;
            $display("FAIL stretch c=%0d: got %h required %h", c, obs(1), expv(1));
         end
         if (done_o[1] === 1'b1) done_at = c;
      end
      tests++;
      if (done_at != 15) begin
         fails++;
         $display("FAIL stretch_len: done at %0d required 15", done_at);
      end
      en[1] = 1'b0;
   endtask

   task automatic test_zero_and_abort();
      lv[0] = 1'b1; ld[0] = 16'h0000; en[0] = 1'b1;
      step();
      lv[0] = 1'b0;
      tests++;
      if (obs(0) !== {16'h0000, 1'b0, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL zero_load: got %h required %h", obs(0), {16'h0000, 3'b011});
      end
      step();
      tests++;
      if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
         fails++;
         $display("FAIL zero_load_after: done=%b busy=%b required 0 0", done_o[0], busy_o[0]);
      end
      lv[0] = 1'b1; ld[0] = 16'h0002;
      step();
      lv[0] = 1'b0;
      step();               // count now 1; next edge would be terminal
      ab[0] = 1'b1;
      step();
      ab[0] = 1'b0;
      tests++;
      if (obs(0) !== {16'h0001, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL abort_terminal: got %h required %h", obs(0), {16'h0001, 3'b001});
      end
      step();
      tests++;
      if (done_o[0] !== 1'b0 || cnt_o[0] !== 16'h0001) begin
         fails++;
         $display("FAIL abort_after: done=%b count=%h required 0 0001", done_o[0], cnt_o[0]);
      end
      en[0] = 1'b0;
   endtask

   task automatic test_reset_midrun();
      bit seen_done = 1'b0;
      bit reached = 1'b0;
      lv[1] = 1'b1; ld[1] = 16'h00A5; en[1] = 1'b1;
      step();
      lv[1] = 1'b0;
      for (int k = 0; k < 60 && !reached; k++) begin
         step();
         if (done_o[1] === 1'b1) seen_done = 1'b1;
         if (cnt_o[1] === 16'h00A0) reached = 1'b1;
      end
      tests++;
      if (!reached) begin
         fails++;
         $display("FAIL midrun_reach: count=%h required 00a0 within 60 cycles", cnt_o[1]);
      end
      reset = 1'b0;
      step();
      tests++;
      if (obs(1) !== {16'h0000, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL midrun_reset: got %h required %h", obs(1), {16'h0000, 3'b001});
      end
      reset = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         if (done_o[1] === 1'b1) seen_done = 1'b1;
      end
      tests++;
      if (seen_done || busy_o[1] !== 1'b0) begin
         fails++;
         $display("FAIL midrun_nodone: done seen=%b busy=%b required 0 0", seen_done, busy_o[1]);
      end
      en[1] = 1'b0;
   endtask

`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
   task automatic test_reload();
      logic [15:0] exp_c;
      ar[0] = 1'b1; en[0] = 1'b1; lv[0] = 1'b1; ld[0] = 16'h0004;
      step();
      lv[0] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         exp_c = 16'(4 - (k % 4));
         tests++;
         if (cnt_o[0] !== exp_c || done_o[0] !== (k % 4 == 0) || busy_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL reload k=%0d: count=%h done=%b busy=%b required %h %b 1", k, cnt_o[0], done_o[0], busy_o[0], exp_c, (k % 4 == 0));
         end
      end
      ar[0] = 1'b0;
      for (int k = 1; k <= 4; k++) step();
      tests++;
      if (obs(0) !== {16'h0000, 1'b0, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL reload_drop: got %h required %h", obs(0), {16'h0000, 3'b011});
      end
      en[0] = 1'b0;
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            lv[i] = ($urandom_range(0, 3) == 0);
            ld[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 9));
            en[i] = ($urandom_range(0, 3) != 0);
            ab[i] = ($urandom_range(0, 29) == 0);
            ar[i] = $urandom_range(0, 1) == 1;
         end
         reset = ($urandom_range(0, 199) != 0);
         step();
         for (int i = 0; i < 2; i++) begin
            tests++;
            if (obs(i) !== expv(i)) begin
               fails++;
               $display("FAIL random c=%0d inst%0d: got %h required %h", c, i, obs(i), expv(i));
            end
         end
      end
      idle_inputs();
      reset = 1'b1;
      step();
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      test_reset();
      test_countdown_p1();
      test_borrow_p4();
      test_zero_and_abort();
      test_reset_midrun();
`ifdef SIXTEEN_BIT_DOWN_COUNTER_RELOAD_EN
      test_reload();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
